// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences a 16-bit asynchronous SRAM (18-bit halfword address)
// for a 32-bit valid/ready memory port. Each word access is split into a
// low (even halfword) and/or high (odd halfword) bus phase. Each phase holds
// address and strobes for WAIT_CYCLES cycles.
//
// Ports:
//   clock, reset           - single clock, synchronous active-high reset
//   mem_valid/mem_ready    - request handshake; mem_ready is a 1-cycle pulse
//   mem_addr               - byte address, bits [18:2] select the word
//   mem_wdata/mem_wstrb    - write data and byte strobes (0000 = read)
//   mem_rdata              - read data, valid while mem_ready=1
//   sram_*                 - SRAM pins (active-low strobes, address, data bus)
//
// Every output is registered and is computed from the current state. The pins
// therefore trail the FSM by one cycle. Read data is sampled one cycle after
// the FSM leaves a phase, because that is the last cycle in which the pins
// still show that phase.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        sram_ce_n,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  // request latched at accept; later changes on mem_* are ignored
  logic [16:0] req_wa;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_rd;

  logic [15:0] rd_lo;
  logic        dq_oe;
  logic [15:0] dq_out;

  // next values of the output registers
  logic        ce_d, we_d, oe_d, ub_d, lb_d, dq_oe_d;
  logic [17:0] addr_d;
  logic [15:0] dq_out_d;
  logic        phase_act, hi_sel;
  logic [1:0]  lanes;

  // bits [31:19] alias and [1:0] select bytes already covered by wstrb
  logic        addr_unused;
  assign addr_unused = ^{mem_addr[31:19], mem_addr[1:0]};

  assign req_rd  = (req_wstrb == 4'b0000);
  assign sram_dq = dq_oe ? dq_out : 16'bz;

  // next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          cnt_nxt = 4'd0;
          // a write touching only the upper halfword skips the LO phase
          if (mem_wstrb != 4'b0000 && mem_wstrb[1:0] == 2'b00)
            state_nxt = HI;
          else
            state_nxt = LO;
        end
      end
      LO: begin
        if (cnt == LAST) begin
          cnt_nxt = 4'd0;
          if (req_rd || req_wstrb[3:2] != 2'b00)
            state_nxt = HI;
          else
            state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HI: begin
        if (cnt == LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pin values for the phase the FSM is in now
  always_comb begin
    phase_act = (state == LO) || (state == HI);
    hi_sel    = (state == HI);
    lanes     = hi_sel ? req_wstrb[3:2] : req_wstrb[1:0];
    ce_d      = 1'b1;
    we_d      = 1'b1;
    oe_d      = 1'b1;
    ub_d      = 1'b1;
    lb_d      = 1'b1;
    dq_oe_d   = 1'b0;
    addr_d    = sram_addr;
    dq_out_d  = hi_sel ? req_wdata[31:16] : req_wdata[15:0];
    if (phase_act) begin
      ce_d   = 1'b0;
      addr_d = {req_wa, hi_sel};
      if (req_rd) begin
        oe_d = 1'b0;
        ub_d = 1'b0;
        lb_d = 1'b0;
      end else begin
        // the bus is only driven with oe_n high, so it never contends with the SRAM
        we_d    = 1'b0;
        ub_d    = ~lanes[1];
        lb_d    = ~lanes[0];
        dq_oe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_wa    <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      rd_lo     <= '0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
      sram_addr <= '0;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && mem_valid) begin
        req_wa    <= mem_addr[18:2];
        req_wdata <= mem_wdata;
        req_wstrb <= mem_wstrb;
      end
      sram_ce_n <= ce_d;
      sram_we_n <= we_d;
      sram_oe_n <= oe_d;
      sram_ub_n <= ub_d;
      sram_lb_n <= lb_d;
      sram_addr <= addr_d;
      dq_oe     <= dq_oe_d;
      dq_out    <= dq_out_d;
      // first HI cycle: the pins still show the final LO cycle
      if (state == HI && cnt == 4'd0 && req_rd)
        rd_lo <= sram_dq;
      // DONE: the pins still show the final HI cycle
      if (state == DONE && req_rd)
        mem_rdata <= {sram_dq, rd_lo};
      mem_ready <= (state == DONE);
    end
  end

endmodule
